bcd_multi_counter: RTL

//   Parametrised N-digit BCD up/down counter with 7-segment outputs. Successor to
//   the fixed 2-digit 18->00 down counter. Adds:
//     - configurable digit count, preset and upper limit;
//     - run-time direction, wrap/saturate mode and parallel load with BCD check;
//     - a terminal-count pulse and optional leading-zero blanking.

---
 rtl/bcd_multi_counter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bcd_multi_counter.sv
`default_nettype none
// ============================================================================
// bcd_multi_counter : N-digit BCD up/down counter with 7-segment outputs
// Revision: 1.0
// ============================================================================
module bcd_multi_counter #(
   parameter int unsigned         DIGITS   = 2,
   parameter logic [4*DIGITS-1:0] PRESET   = 'h18,
   parameter logic [4*DIGITS-1:0] LIMIT    = 'h18,
   parameter bit                  BLANK_LZ = 1'b0
) (
   input  logic                  ck,
   input  logic                  rs,
   input  logic                  en,
   input  logic                  up,
   input  logic                  wrap,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   q,
   output logic                  tc,
   output logic                  load_err,
   output logic [8*DIGITS-1:0]   hex
);
   localparam int unsigned W = 4*DIGITS;

   function automatic logic bcd_ok(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   if (DIGITS < 1 || DIGITS > 8 || !bcd_ok(PRESET) || !bcd_ok(LIMIT) || PRESET > LIMIT)
   begin : g_bad_param
      $error("bcd_multi_counter: DIGITS, PRESET or LIMIT out of range / not BCD");
   end

   logic [W-1:0] count_q, count_d;
   logic         tc_q, tc_d;
   logic         err_q, err_d;
   logic [W-1:0] step_up, step_dn;
   logic         all9, all0;
   logic         load_ok, terminal;
   logic [3:0]   digit;

   // Ripple the BCD carry/borrow digit by digit so no binary value ever forms.
   always_comb begin
      step_up = count_q;
      step_dn = count_q;
      all9    = 1'b1;
      all0    = 1'b1;
      digit   = 4'd0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         digit = count_q[4*i +: 4];
         if (all9) step_up[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
         if (all0) step_dn[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
         all9 = all9 && (digit == 4'd9);
         all0 = all0 && (digit == 4'd0);
      end
   end

   assign load_ok  = bcd_ok(load_val) && (load_val <= LIMIT);
   assign terminal = up ? (count_q == LIMIT) : (count_q == '0);

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      err_d   = 1'b0;
      if (load) begin
         if (load_ok) count_d = load_val;
         else         err_d   = 1'b1;
      end else if (en) begin
         if (terminal) begin
            tc_d = 1'b1;
            if (wrap) count_d = up ? '0 : LIMIT;
         end else begin
            count_d = up ? step_up : step_dn;
         end
      end
   end

   always_ff @(posedge ck) begin
      if (rs) begin
         count_q <= PRESET;
         tc_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         err_q   <= err_d;
      end
   end

   assign q        = count_q;
   assign tc       = tc_q;
   assign load_err = err_q;

   // Walk from the top digit down; digit 0 is never blanked.
   logic hi_zero;
   always_comb begin
      hex     = '1;
      hi_zero = 1'b1;
      for (int j = int'(DIGITS) - 1; j >= 0; j--) begin
         hi_zero = hi_zero && (count_q[4*j +: 4] == 4'd0);
         if (BLANK_LZ && (j > 0) && hi_zero) hex[8*j +: 8] = 8'hFF;
         else                                hex[8*j +: 8] = seg7(count_q[4*j +: 4]);
      end
   end
endmodule
`default_nettype wire
